fpu_fflags_stage: RTL

Memory-to-writeback stage for FMA exception flags. Registers the invalid/overflow/underflow/inexact (plus divide-by-zero) outputs of the FMA flag generator alongside the instruction's valid bit, honours writeback stall and flush, and ORs the flags of each retiring FP instruction into the sticky 5-bit `fflags` CSR. Also serves the CSR write/set/clear port for `fflags` and raises a one-cycle dirty pulse for `mstatus.FS`.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/fflags_norm.sv | 23 ++
 rtl/fpu_fflags_stage.sv | 82 ++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and types for the FP exception-flag path.
// Flag vectors are packed {NV, DZ, OF, UF, NX}.
package fpu_pkg;

  localparam int FFLAGS_W = 5;
  localparam int NV_B     = 4;
  localparam int DZ_B     = 3;
  localparam int OF_B     = 2;
  localparam int UF_B     = 1;
  localparam int NX_B     = 0;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_t;

endpackage

// File: rtl/fflags_norm.sv
// M-stage flag normalisation: overflow is always inexact, and an invalid
// operation yields a canonical NaN, which is exact and neither overflows nor underflows.
module fflags_norm
  import fpu_pkg::*;
(
  input  logic                invalid_i,
  input  logic                divzero_i,
  input  logic                overflow_i,
  input  logic                underflow_i,
  input  logic                inexact_i,
  output logic [FFLAGS_W-1:0] flags_o
);

  always_comb begin
    flags_o       = '0;
    flags_o[NV_B] = invalid_i;
    flags_o[DZ_B] = divzero_i;
    flags_o[OF_B] = overflow_i  & ~invalid_i;
    flags_o[UF_B] = underflow_i & ~invalid_i;
    flags_o[NX_B] = (inexact_i | overflow_i) & ~invalid_i;
  end

endmodule

// File: rtl/fpu_fflags_stage.sv
// Memory-to-writeback register for FP exception flags, plus the sticky
// fflags CSR with write/set/clear access and an mstatus.FS dirty pulse.
module fpu_fflags_stage
  import fpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall_w,
  input  logic                flush_w,
  input  logic                fpvalid_m,
  input  logic                invalid_m,
  input  logic                divzero_m,
  input  logic                overflow_m,
  input  logic                underflow_m,
  input  logic                inexact_m,
  input  logic [1:0]          csr_op_w,
  input  logic [FFLAGS_W-1:0] csr_wdata_w,
  output logic [FFLAGS_W-1:0] fflags_o,
  output logic [FFLAGS_W-1:0] flags_w_o,
  output logic                fs_dirty_o
);

  logic [FFLAGS_W-1:0] flags_m;
  logic                valid_w_q;
  logic [FFLAGS_W-1:0] flags_w_q;
  logic [FFLAGS_W-1:0] fflags_q, fflags_d, fflags_csr;
  logic                fs_dirty_q, fs_dirty_d;
  logic                retire_w;
  logic                csr_exec;

  fflags_norm u_norm (
    .invalid_i   (invalid_m),
    .divzero_i   (divzero_m),
    .overflow_i  (overflow_m),
    .underflow_i (underflow_m),
    .inexact_i   (inexact_m),
    .flags_o     (flags_m)
  );

  assign retire_w = valid_w_q & ~stall_w & ~flush_w;
  assign csr_exec = (csr_op_w != CSR_NONE) & ~stall_w & ~flush_w;

  // CSR op first, then retiring flags OR'd on top so a simultaneous write
  // cannot erase the older instruction's exceptions.
  always_comb begin
    fflags_csr = fflags_q;
    if (csr_exec) begin
      case (csr_op_t'(csr_op_w))
        CSR_WRITE: fflags_csr = csr_wdata_w;
        CSR_SET:   fflags_csr = fflags_q | csr_wdata_w;
        CSR_CLEAR: fflags_csr = fflags_q & ~csr_wdata_w;
        default:   fflags_csr = fflags_q;
      endcase
    end
    fflags_d   = fflags_csr | (retire_w ? flags_w_q : '0);
    fs_dirty_d = (fflags_d != fflags_q) | csr_exec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_w_q  <= 1'b0;
      flags_w_q  <= '0;
      fflags_q   <= '0;
      fs_dirty_q <= 1'b0;
    end else begin
      if (flush_w) begin
        valid_w_q <= 1'b0;
        flags_w_q <= '0;
      end else if (!stall_w) begin
        valid_w_q <= fpvalid_m;
        flags_w_q <= fpvalid_m ? flags_m : '0;
      end
      fflags_q   <= fflags_d;
      fs_dirty_q <= fs_dirty_d;
    end
  end

  assign fflags_o   = fflags_q;
  assign fs_dirty_o = fs_dirty_q;
  assign flags_w_o  = valid_w_q ? flags_w_q : '0;

endmodule
